// File: rtl/branch_flag_ctrl_pkg.sv
// Shared definitions for the branch/flag controller: FSM encoding,
// condition-select codes and flag bit positions.
package branch_flag_ctrl_pkg;

  localparam int FLAG_W = 5;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } br_state_e;

  localparam logic [SEL_W-1:0] COND_ALWAYS = 3'd5;
  localparam logic [SEL_W-1:0] COND_NZ     = 3'd6;
  localparam logic [SEL_W-1:0] COND_NEVER  = 3'd7;

  localparam int FLG_Z = 0;
  localparam int FLG_S = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;
  localparam int FLG_P = 4;

endpackage

// File: rtl/branch_flag_ctrl_cond_select.sv
// Maps a condition-select code and the flag register onto a single
// branch decision bit. Purely combinational.
module branch_flag_ctrl_cond_select
  import branch_flag_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [FLAG_W-1:0] flag_i,
  output logic              cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (sel_i)
      3'd0:        cond_o = flag_i[FLG_Z];
      3'd1:        cond_o = flag_i[FLG_S];
      3'd2:        cond_o = flag_i[FLG_C];
      3'd3:        cond_o = flag_i[FLG_V];
      3'd4:        cond_o = flag_i[FLG_P];
      COND_ALWAYS: cond_o = 1'b1;
      COND_NZ:     cond_o = ~flag_i[FLG_Z];
      COND_NEVER:  cond_o = 1'b0;
      default:     cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_ctrl.sv
// Conditional-branch sequencer: owns the flag register, evaluates the
// selected condition over IDLE -> EVAL -> COMMIT and drives the PC unit.
module branch_flag_ctrl
  import branch_flag_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLAG_W-1:0] F_IN,
  input  logic              FLAG_WE,
  input  logic              BR_REQ,
  input  logic [SEL_W-1:0]  SEL_F,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic              PC_RDY,
  output logic [FLAG_W-1:0] R_FLAG,
  output logic              S_FLAG,
  output logic              BR_ACCEPT,
  output logic              BR_BUSY,
  output logic              PC_LOAD,
  output logic              PC_INC,
  output logic [ADDR_W-1:0] PC_TARGET,
  output logic              BR_DONE,
  output logic [CNT_W-1:0]  TAKEN_CNT
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  br_state_e         state_q, state_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              s_flag_q, s_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cond;
  logic              accept;
  logic              commit_fire;

  branch_flag_ctrl_cond_select u_cond_select (
    .sel_i  (sel_q),
    .flag_i (flag_q),
    .cond_o (cond)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (BR_REQ) state_d = EVAL;
      EVAL:    state_d = COMMIT;
      COMMIT:  if (PC_RDY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the pulses so an aborted sequence never reaches the PC
  always_comb begin
    accept      = ~RST & (state_q == IDLE) & BR_REQ;
    commit_fire = ~RST & (state_q == COMMIT) & PC_RDY;
    BR_ACCEPT   = accept;
    BR_BUSY     = (state_q != IDLE);
    BR_DONE     = commit_fire;
    PC_LOAD     = commit_fire & s_flag_q;
    PC_INC      = commit_fire & ~s_flag_q;
  end

  always_comb begin
    flag_d   = FLAG_WE ? F_IN : flag_q;
    sel_d    = accept ? SEL_F : sel_q;
    target_d = accept ? BR_TARGET : target_q;
    s_flag_d = (state_q == EVAL) ? cond : s_flag_q;
    cnt_d    = commit_fire ? sat_inc(cnt_q, s_flag_q) : cnt_q;
  end

  // Latched request, decision, flags and debug counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_q   <= '0;
      sel_q    <= '0;
      target_q <= '0;
      s_flag_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flag_q   <= flag_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      s_flag_q <= s_flag_d;
      cnt_q    <= cnt_d;
    end
  end

  assign R_FLAG    = flag_q;
  assign S_FLAG    = s_flag_q;
  assign PC_TARGET = target_q;
  assign TAKEN_CNT = cnt_q;

endmodule
